// File: rtl/sd4_pp_accumulator.sv
// SD4 partial-product accumulator: sums signed_pp << exp terms, emits result on last.
// Optional SD4_ACC_SAT_EN: clamp the accumulator on overflow instead of wrapping.
module sd4_pp_accumulator #(
  parameter int PP_W  = 5,
  parameter int EXP_W = 5,
  parameter int ACC_W = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PP_W-1:0]  signed_pp,
  input  logic [EXP_W-1:0] exp,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] result,
  output logic [CNT_W-1:0] term_cnt,
  output logic             ovf
);

  // Exact term width plus one carry bit for the sum.
  localparam int TW = ACC_W + (1 << EXP_W);
  localparam int SW = TW + 1;

  localparam logic [0:0] S_ACCUM = 1'b0;
  localparam logic [0:0] S_HOLD  = 1'b1;

  logic [0:0]       r_state;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_result;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;

  logic             w_accept;
  logic [SW-1:0]    w_pp_ext;
  logic [SW-1:0]    w_term;
  logic [SW-1:0]    w_acc_ext;
  logic [SW-1:0]    w_sum;
  logic [SW-ACC_W:0] w_hi;
  logic             w_ovf;
  logic [ACC_W-1:0] w_next_acc;
  logic [CNT_W-1:0] w_cnt_next;

  assign in_ready  = (r_state == S_ACCUM);
  assign out_valid = (r_state == S_HOLD);
  assign result    = r_result;
  assign term_cnt  = r_cnt;
  assign ovf       = r_ovf;

  assign w_accept  = in_valid & in_ready;

  // Exact sum: sign-extend both operands wide enough that no bit is lost.
  always_comb begin
    w_pp_ext  = {{(SW-PP_W){signed_pp[PP_W-1]}}, signed_pp};
    w_term    = w_pp_ext << exp;
    w_acc_ext = {{(SW-ACC_W){r_acc[ACC_W-1]}}, r_acc};
    w_sum     = w_acc_ext + w_term;
    // In range only if all bits from the ACC_W sign bit upward agree.
    w_hi      = w_sum[SW-1:ACC_W-1];
    w_ovf     = (|w_hi) & ~(&w_hi);
  end

  // Next accumulator value: clamp or wrap when the sum leaves the range.
  always_comb begin
    w_next_acc = w_sum[ACC_W-1:0];
`ifdef SD4_ACC_SAT_EN
    if (w_ovf) begin
      if (w_sum[SW-1])
        w_next_acc = {1'b1, {(ACC_W-1){1'b0}}};
      else
        w_next_acc = {1'b0, {(ACC_W-1){1'b1}}};
    end
`endif
  end

  // Term counter saturates at all-ones.
  always_comb begin
    w_cnt_next = r_cnt;
    if (!(&r_cnt))
      w_cnt_next = r_cnt + CNT_W'(1);
  end

  // Accumulate terms in ACCUM, hold the result until downstream takes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_ACCUM;
      r_acc    <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
    end else if (r_state == S_ACCUM) begin
      if (w_accept) begin
        r_acc <= w_next_acc;
        r_cnt <= w_cnt_next;
        r_ovf <= r_ovf | w_ovf;
        if (in_last) begin
          r_result <= w_next_acc;
          r_state  <= S_HOLD;
        end
      end
    end else begin
      if (out_ready) begin
        r_state <= S_ACCUM;
        r_acc   <= '0;
        r_cnt   <= '0;
        r_ovf   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sd4_pp_accumulator.sv
// Bench for sd4_pp_accumulator: 32-bit and 8-bit instances share one input stream.
// Vector table, hand sequences, and random MACs against an arithmetic model.
module tb_sd4_pp_accumulator;

`ifdef SD4_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_last;
  logic       out_ready;
  logic [4:0] signed_pp;
  logic [4:0] exp_i;

  logic        a_ir, a_ov, a_ovf;
  logic [31:0] a_res;
  logic [7:0]  a_cnt;
  logic        b_ir, b_ov, b_ovf;
  logic [7:0]  b_res;
  logic [7:0]  b_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  longint m32, m8;
  bit     mo32, mo8;
  int     mcnt;

  typedef struct {
    int          pp;
    int          e;
    bit          last;
    logic [31:0] r32;
    bit          o32;
    logic [7:0]  r8;
    bit          o8;
    int          cnt;
  } vec_t;

  vec_t tbl[$];

  sd4_pp_accumulator #(.PP_W(5), .EXP_W(5), .ACC_W(32), .CNT_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_ir),
    .signed_pp(signed_pp), .exp(exp_i), .in_last(in_last),
    .out_valid(a_ov), .out_ready(out_ready), .result(a_res),
    .term_cnt(a_cnt), .ovf(a_ovf));

  sd4_pp_accumulator #(.PP_W(5), .EXP_W(5), .ACC_W(8), .CNT_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_ir),
    .signed_pp(signed_pp), .exp(exp_i), .in_last(in_last),
    .out_valid(b_ov), .out_ready(out_ready), .result(b_res),
    .term_cnt(b_cnt), .ovf(b_ovf));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Reference: exact sum, then wrap or clamp into a w-bit signed range.
  function automatic void madd(inout longint acc, inout bit o,
                               input int w, input int pp, input int e);
    longint s, lim;
    s   = acc + longint'(pp) * (longint'(1) << e);
    lim = longint'(1) << (w - 1);
    if (s >= lim || s < -lim) begin
      o = 1'b1;
      if (SAT) begin
        acc = (s > 0) ? lim - 1 : -lim;
      end else begin
        acc = s & (2 * lim - 1);
        if (acc >= lim) acc = acc - 2 * lim;
      end
    end else begin
      acc = s;
    end
  endfunction

  task automatic mreset();
    m32 = 0; m8 = 0; mo32 = 0; mo8 = 0; mcnt = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [31:0] e32;
    logic [7:0]  e8;
    logic [7:0]  ec;
    e32 = m32[31:0];
    e8  = m8[7:0];
    ec  = mcnt[7:0];
    chk({tag, ".res32"}, 64'(a_res), 64'(e32));
    chk({tag, ".res8"}, 64'(b_res), 64'(e8));
    chk({tag, ".cnt32"}, 64'(a_cnt), 64'(ec));
    chk({tag, ".cnt8"}, 64'(b_cnt), 64'(ec));
    chk({tag, ".ovf32"}, 64'(a_ovf), 64'(mo32));
    chk({tag, ".ovf8"}, 64'(b_ovf), 64'(mo8));
  endtask

  task automatic send(input int pp, input int e, input bit last,
                      input int gap);
    int w;
    logic [31:0] ppv, ev;
    repeat (gap) step();
    ppv = pp;
    ev  = e;
    signed_pp = ppv[4:0];
    exp_i     = ev[4:0];
    in_last   = last;
    in_valid  = 1'b1;
    w = 0;
    while (!a_ir && w < 50) begin
      step();
      w++;
    end
    if (!a_ir) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got in_ready 0 want 1");
      in_valid = 1'b0;
      return;
    end
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    mcnt = (mcnt < 255) ? mcnt + 1 : 255;
    madd(m32, mo32, 32, pp, e);
    madd(m8, mo8, 8, pp, e);
    if (last) begin
      chk("latency32", 64'(a_ov), 64'd1);
      chk("latency8", 64'(b_ov), 64'd1);
    end
  endtask

  task automatic collect(input int hold);
    for (int i = 0; i < hold; i++) begin
      chk("hold.valid", 64'(a_ov), 64'd1);
      chk("hold.in_ready", 64'(a_ir), 64'd0);
      check_model("hold");
      step();
    end
    chk("pre.valid", 64'(a_ov & b_ov), 64'd1);
    check_model("done");
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("post.valid", 64'(a_ov | b_ov), 64'd0);
    chk("post.in_ready", 64'(a_ir & b_ir), 64'd1);
    mreset();
  endtask

  function automatic vec_t mk(int pp, int e, bit last, logic [31:0] r32,
                              bit o32, logic [7:0] r8, bit o8, int cnt);
    vec_t v;
    v.pp = pp; v.e = e; v.last = last;
    v.r32 = r32; v.o32 = o32; v.r8 = r8; v.o8 = o8; v.cnt = cnt;
    return v;
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, ".res"}, 64'(a_res), 64'd0);
    chk({tag, ".cnt"}, 64'(a_cnt), 64'd0);
    chk({tag, ".ovf"}, 64'(a_ovf | b_ovf), 64'd0);
    chk({tag, ".valid"}, 64'(a_ov | b_ov), 64'd0);
    chk({tag, ".in_ready"}, 64'(a_ir & b_ir), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    signed_pp = '0; exp_i = '0;
    mreset();
    step(); step();
    rst_n = 1'b1;
    check_reset("reset");

    tbl.push_back(mk(7, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(7, 2, 1, 32'd35, 0, 8'd35, 0, 2));
    tbl.push_back(mk(-3, 4, 1, 32'hFFFFFFD0, 0, 8'hD0, 0, 1));
    tbl.push_back(mk(15, 3, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 3, 1, 32'd128, 0, SAT ? 8'h7F : 8'h80, 1, 2));
    tbl.push_back(mk(-16, 3, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(-1, 0, 1, 32'hFFFFFF7F, 0, SAT ? 8'h80 : 8'h7F, 1, 2));
    tbl.push_back(mk(1, 31, 1, SAT ? 32'h7FFFFFFF : 32'h80000000, 1,
                     SAT ? 8'h7F : 8'h00, 1, 1));
    tbl.push_back(mk(-16, 31, 1, SAT ? 32'h80000000 : 32'h0, 1,
                     SAT ? 8'h80 : 8'h00, 1, 1));
    tbl.push_back(mk(0, 5, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(4, 0, 1, 32'd4, 0, 8'd4, 0, 2));
    tbl.push_back(mk(15, 3, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(-4, 0, 1, 32'd124, 0, SAT ? 8'd123 : 8'd124, 1, 3));

    foreach (tbl[i]) begin
      send(tbl[i].pp, tbl[i].e, tbl[i].last, 0);
      if (tbl[i].last) begin
        chk($sformatf("tbl%0d.res32", i), 64'(a_res), 64'(tbl[i].r32));
        chk($sformatf("tbl%0d.ovf32", i), 64'(a_ovf), 64'(tbl[i].o32));
        chk($sformatf("tbl%0d.res8", i), 64'(b_res), 64'(tbl[i].r8));
        chk($sformatf("tbl%0d.ovf8", i), 64'(b_ovf), 64'(tbl[i].o8));
        chk($sformatf("tbl%0d.cnt", i), 64'(a_cnt), 64'(tbl[i].cnt));
        collect(0);
      end
    end

    // Backpressure with a term waiting; it is taken only after the handshake.
    send(1, 0, 0, 0);
    send(2, 0, 1, 0);
    signed_pp = 5'd9; exp_i = 5'd0; in_last = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("bp.in_ready", 64'(a_ir), 64'd0);
      chk("bp.res", 64'(a_res), 64'd3);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp.hs_valid", 64'(a_ov), 64'd0);
    chk("bp.hs_in_ready", 64'(a_ir), 64'd1);
    mreset();
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    mcnt = 1;
    madd(m32, mo32, 32, 9, 0);
    madd(m8, mo8, 8, 9, 0);
    chk("bp.next_valid", 64'(a_ov), 64'd1);
    chk("bp.next_res", 64'(a_res), 64'd9);
    collect(0);

    // Reset mid-accumulation discards the partial sum.
    send(1, 0, 0, 0);
    send(2, 0, 0, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    mreset();
    check_reset("midrst");
    send(3, 1, 1, 0);
    chk("midrst.res", 64'(a_res), 64'd6);
    chk("midrst.cnt", 64'(a_cnt), 64'd1);
    collect(1);

    // Reset with a pending result discards it.
    send(5, 0, 1, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    mreset();
    check_reset("pendrst");

    // Term counter saturation.
    for (int i = 0; i < 300; i++) send(0, 0, (i == 299), 0);
    chk("sat.cnt", 64'(a_cnt), 64'd255);
    collect(0);

    // Random MACs with idle gaps and output backpressure.
    for (int m = 0; m < 150; m++) begin
      int nt;
      nt = $urandom_range(1, 5);
      for (int t = 0; t < nt; t++) begin
        int pp, e;
        pp = int'($urandom_range(0, 31)) - 16;
        e  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 4))
                                         : int'($urandom_range(0, 31));
        send(pp, e, (t == nt - 1), int'($urandom_range(0, 2)));
      end
      collect(int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sd4_pp_accumulator.md
Name: sd4_pp_accumulator

Overview:
Consumer end of the SD4 partial-product interface. Accepts a stream of (signed_pp, exp) terms from the partial-product generator over a valid/ready handshake. Accumulates each term as signed_pp shifted left by exp. On the term flagged last, presents the finished MAC result on a second valid/ready handshake. Sits between the partial-product generator and the output/requant stage of the SD4 MAC.

Parameters:
PP_W, 5, width of signed_pp (two's complement)
EXP_W, 5, width of exp (unsigned left-shift amount, 0..2^EXP_W-1)
ACC_W, 32, accumulator/result width (two's complement)
CNT_W, 8, term counter width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  term present
in_ready  output  1  block can take a term
signed_pp  input  PP_W  signed partial product
exp  input  EXP_W  shift amount for signed_pp
in_last  input  1  final term of current MAC
out_valid  output  1  result available
out_ready  input  1  downstream takes result
result  output  ACC_W  accumulated value
term_cnt  output  CNT_W  terms accepted in this MAC, held with result
ovf  output  1  sticky overflow for the current MAC

Behaviour:
- Reset (rst_n=0 at a rising edge): state ACCUM, acc=0, term_cnt=0, ovf=0, out_valid=0, result=0. in_ready=1 once rst_n=1. Reset wins over every other event, including mid-accumulation and a pending result. A pending result is discarded.
- Term value: sign-extend signed_pp, then shift left by exp. Compute exactly, with no bit loss, at ACC_W+2^EXP_W bits. The exact sum is acc + term.
- Overflow: the exact sum falls outside the signed ACC_W range. Set ovf sticky. Default behaviour wraps: acc takes the low ACC_W bits of the sum.
- State ACCUM: in_ready=1, out_valid=0. On in_valid&in_ready, acc updates with the term. term_cnt increments, saturating at 2^CNT_W-1.
  - If in_last is also high, go to HOLD. In HOLD, result takes the updated acc, and out_valid=1 starting the cycle after acceptance. Latency from the last term to out_valid is 1 cycle.
- State HOLD: in_ready=0. result, term_cnt and ovf are held stable while out_valid=1 and out_ready=0.
  - On out_valid&out_ready: acc=0, term_cnt=0, ovf=0, out_valid=0, and the state returns to ACCUM. in_ready=1 from the next cycle. A term offered in the handshake cycle is not accepted that cycle.
- in_valid while in_ready=0: ignored. The upstream holds its term.
- exp=0: the term equals signed_pp. signed_pp=0: acc is unchanged, but term_cnt still increments.
- A single-term MAC (first term has in_last=1) is legal and produces result=term.
- out_valid never drops without out_ready. in_ready is a registered state decode and has no combinational path from out_ready.

Optional Feature:
Macro name: SD4_ACC_SAT_EN.
- Defined: on overflow, acc clamps to 2^(ACC_W-1)-1 (positive overflow) or -2^(ACC_W-1) (negative overflow). Later terms add to the clamped value and are checked again. ovf is still set.
- Undefined: wrap-around as above. ovf is still reported.

Test Plan:
1. Terms (7,0) then (7,2,last) → result=35, term_cnt=2, ovf=0. out_valid rises 1 cycle after the second accept.
2. Single term (5'b11101 = -3, exp 4, last) → result=-48 (0xFFFFFFD0), term_cnt=1.
3. After a 2-term MAC completes, hold out_ready=0 for 3 cycles with in_valid=1 → result stable, in_ready=0, no term consumed. The out_ready=1 cycle is the handshake. The next term is accepted the following cycle, and acc restarts from 0.
4. Set ACC_W=8 and send (15,3) then (1,3,last) → without the macro, result=-128 and ovf=1. With SD4_ACC_SAT_EN, result=127 and ovf=1.
5. Set ACC_W=8 and send (-16,3)=-128 then (-1,0,last) → wrap gives result=127 and ovf=1. Saturation gives result=-128 and ovf=1.
6. Accept 2 terms of a 4-term MAC, assert rst_n=0 for one cycle, then send (3,1,last) → result=6, term_cnt=1, ovf=0. No stale partial sum remains.
